// File: rtl/mode_speed_pkg.sv
// Shared encodings and default select values for the mode/speed front end.
package mode_speed_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_e;

  localparam logic [1:0] SW_DEF   = 2'd0;
  localparam logic [1:0] MODE_DEF = 2'd0;

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser + debounce FSM with long-press detection.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | key released and stable
// PRESS_WAIT | key seen low, waiting DEB_CYC stable cycles
// HELD       | press accepted, hold counter measuring press length
// REL_WAIT   | key seen high, waiting DEB_CYC stable cycles
module key_debounce
  import mode_speed_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned LONG_CYC = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_n,
  output logic press_p,
  output logic long_p,
  output logic rel_p,
  output logic was_long
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYC);

  logic [1:0]       sync_q;
  logic             key_s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             press_q, press_d;
  logic             long_q, long_d;
  logic             rel_q, rel_d;
  logic             was_long_q, was_long_d;

  assign key_s    = sync_q[1];
  assign press_p  = press_q;
  assign long_p   = long_q;
  assign rel_p    = rel_q;
  assign was_long = was_long_q;

  // Two-stage synchroniser, preset to the released level.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  // State, counters and registered event pulses.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      rel_q      <= 1'b0;
      was_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
      long_q     <= long_d;
      rel_q      <= rel_d;
      was_long_q <= was_long_d;
    end
  end

  // Next-state logic; hold counter is frozen outside HELD so a bounce
  // back from REL_WAIT resumes timing and long_p cannot fire twice.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    press_d    = 1'b0;
    long_d     = 1'b0;
    rel_d      = 1'b0;
    was_long_d = was_long_q;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (hold_q == LONG_PRE) long_d = 1'b1;
        if (key_s) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = IDLE;
          rel_d      = 1'b1;
          was_long_d = (hold_q >= LONG_LAST);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/mode_speed_ctrl.sv
// Button front end for the LED display: cycles sw/mode selects from
// debounced key events; a long mode press restores both defaults.
module mode_speed_ctrl
  import mode_speed_pkg::*;
#(
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned LONG_CYC = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       key_speed_n,
  input  logic       key_mode_n,
  output logic [1:0] sw,
  output logic [1:0] mode,
  output logic       upd
);

  logic spd_press, spd_long, spd_rel, spd_was_long;
  logic mod_press, mod_long, mod_rel, mod_was_long;
  logic speed_unused;

  logic [1:0] sw_q, sw_d;
  logic [1:0] mode_q, mode_d;
  logic       chg_q, chg_d;
  logic       upd_q;

  key_debounce #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .CNT_W(CNT_W)) u_deb_speed (
    .clk_50   (clk_50),
    .rst      (rst),
    .key_n    (key_speed_n),
    .press_p  (spd_press),
    .long_p   (spd_long),
    .rel_p    (spd_rel),
    .was_long (spd_was_long)
  );

  key_debounce #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .CNT_W(CNT_W)) u_deb_mode (
    .clk_50   (clk_50),
    .rst      (rst),
    .key_n    (key_mode_n),
    .press_p  (mod_press),
    .long_p   (mod_long),
    .rel_p    (mod_rel),
    .was_long (mod_was_long)
  );

  // Only the press event of the speed key drives any action.
  assign speed_unused = ^{spd_long, spd_rel, spd_was_long, mod_press};

  assign sw   = sw_q;
  assign mode = mode_q;
  assign upd  = upd_q;

  // Select update; a long mode press overrides any coincident increment.
  always_comb begin
    sw_d   = sw_q;
    mode_d = mode_q;
    if (spd_press) sw_d = sw_q + 2'd1;
    if (mod_rel && !mod_was_long) mode_d = mode_q + 2'd1;
    if (mod_long) begin
      sw_d   = SW_DEF;
      mode_d = MODE_DEF;
    end
    chg_d = (sw_d != sw_q) || (mode_d != mode_q);
  end

  // Select registers; upd trails the changing edge by one cycle.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      sw_q   <= SW_DEF;
      mode_q <= MODE_DEF;
      chg_q  <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      sw_q   <= sw_d;
      mode_q <= mode_d;
      chg_q  <= chg_d;
      upd_q  <= chg_q;
    end
  end

endmodule
